// File: rtl/spi_capture_pkg.sv
// spi_capture_pkg: shared FSM states, register map and slot constants for the SPI capture scheduler.
package spi_capture_pkg;
   typedef enum logic [1:0] {IDLE, WRITE_REC, WRITE_PTR, CLEAR_PTR} state_e;
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DROPS  = 2'd2;
   localparam logic [1:0] REG_CLEAR  = 2'd3;
   localparam int CTRL_EN        = 0;
   localparam int CTRL_SOF       = 1;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_FULL      = 16;
   localparam int STAT_BUSY      = 17;
   localparam int PTR_SLOT       = 0;
   localparam int FIRST_SLOT     = 1;
endpackage

// File: rtl/spi_capture_rr_arbiter.sv
// spi_capture_rr_arbiter: two-way round-robin grant; last_b_q remembers whether B won the previous grant.
module spi_capture_rr_arbiter (
   input  logic clock,
   input  logic reset,
   input  logic en_i,
   input  logic req_a_i,
   input  logic req_b_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);
   logic last_b_q, last_b_d;
   assign gnt_a_o  = en_i && req_a_i && (!req_b_i || last_b_q);
   assign gnt_b_o  = en_i && req_b_i && !(req_a_i && last_b_q);
   assign last_b_d = (gnt_a_o || gnt_b_o) ? gnt_b_o : last_b_q;
   always_ff @(posedge clock)
      if (reset) last_b_q <= 1'b1;
      else last_b_q <= last_b_d;
endmodule

// File: rtl/spi_capture_scheduler.sv
// spi_capture_scheduler: arbitrates MOSI/MISO capture records into a slot ring and mirrors the next-slot pointer into slot 0.
module spi_capture_scheduler
   import spi_capture_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_MOSI_Valid,
   input  logic [DATA_W-1:0] io_MOSI_Record,
   output logic              io_MOSI_Ready,
   input  logic              io_MISO_Valid,
   input  logic [DATA_W-1:0] io_MISO_Record,
   output logic              io_MISO_Ready,
   output logic              io_Mem_WriteEnable,
   output logic [ADDR_W-1:0] io_Mem_WriteAddress,
   output logic [DATA_W-1:0] io_Mem_WriteData,
   input  logic [1:0]        io_Avalon_address,
   input  logic              io_Avalon_read,
   output logic [DATA_W-1:0] io_Avalon_readdata,
   input  logic              io_Avalon_write,
   input  logic [DATA_W-1:0] io_Avalon_writedata,
   output logic              io_Avalon_waitrequest
);
   localparam logic [ADDR_W-1:0] MAX_SLOT = '1;
   localparam logic [ADDR_W-1:0] FIRST    = ADDR_W'(FIRST_SLOT);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d, count_q, count_d;
   logic [31:0]       drops_q, drops_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [DATA_W-1:0] rec_q, rec_d, status;
   logic              gnt_mosi, gnt_miso, grant, clr_req, accept, full, drop, store;
   logic              unused_bits;

   assign unused_bits = ^{io_Avalon_writedata[DATA_W-1:2], io_Avalon_read};
   assign full    = count_q == MAX_SLOT;
   assign clr_req = io_Avalon_write && io_Avalon_address == REG_CLEAR;
   // a clear is only taken in IDLE, so an in-flight record always finishes both writes first
   assign io_Avalon_waitrequest = clr_req && state_q != IDLE;
   assign accept  = state_q == IDLE && !clr_req && !reset;
   assign grant   = gnt_mosi || gnt_miso;
   assign drop    = grant && ctrl_q[CTRL_EN] && ctrl_q[CTRL_SOF] && full;
   assign store   = grant && ctrl_q[CTRL_EN] && !drop;
   assign io_MOSI_Ready = gnt_mosi;
   assign io_MISO_Ready = gnt_miso;

   spi_capture_rr_arbiter u_arb (
      .clock   (clock),
      .reset   (reset),
      .en_i    (accept),
      .req_a_i (io_MOSI_Valid),
      .req_b_i (io_MISO_Valid),
      .gnt_a_o (gnt_mosi),
      .gnt_b_o (gnt_miso)
   );

   always_ff @(posedge clock)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q == WRITE_REC ? WRITE_PTR :
                state_q != IDLE      ? IDLE :
                clr_req              ? CLEAR_PTR :
                store                ? WRITE_REC : IDLE;
   end

   always_comb begin
      io_Mem_WriteEnable  = state_q != IDLE;
      io_Mem_WriteAddress = state_q == WRITE_REC ? wptr_q : ADDR_W'(PTR_SLOT);
      io_Mem_WriteData    = state_q == WRITE_REC ? rec_q :
                            state_q == WRITE_PTR ? DATA_W'(wptr_q) :
                            state_q == CLEAR_PTR ? DATA_W'(FIRST_SLOT) : '0;
   end

   always_comb begin
      rec_d   = gnt_miso ? io_MISO_Record : gnt_mosi ? io_MOSI_Record : rec_q;
      ctrl_d  = (io_Avalon_write && io_Avalon_address == REG_CTRL) ? io_Avalon_writedata[1:0] : ctrl_q;
      wptr_d  = state_q == CLEAR_PTR ? FIRST :
                state_q == WRITE_REC ? (wptr_q == MAX_SLOT ? FIRST : wptr_q + 1'b1) : wptr_q;
      count_d = state_q == CLEAR_PTR ? '0 :
                (state_q == WRITE_REC && !full) ? count_q + 1'b1 : count_q;
      drops_d = state_q == CLEAR_PTR ? '0 :
                (drop && drops_q != '1) ? drops_q + 32'd1 : drops_q;
   end

   always_ff @(posedge clock)
      if (reset) begin
         wptr_q  <= FIRST;
         count_q <= '0;
         drops_q <= '0;
         ctrl_q  <= 2'b01;
         rec_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         count_q <= count_d;
         drops_q <= drops_d;
         ctrl_q  <= ctrl_d;
         rec_q   <= rec_d;
      end

   always_comb begin
      status                             = '0;
      status[ADDR_W-1:0]                 = wptr_q;
      status[STAT_COUNT_LSB +: ADDR_W]   = count_q;
      status[STAT_FULL]                  = full;
      status[STAT_BUSY]                  = state_q != IDLE;
      io_Avalon_readdata = io_Avalon_address == REG_CTRL   ? DATA_W'(ctrl_q) :
                           io_Avalon_address == REG_STATUS ? status :
                           io_Avalon_address == REG_DROPS  ? DATA_W'(drops_q) : '0;
   end
endmodule

// File: doc/spi_capture_scheduler.md
Name: spi_capture_scheduler

Overview:
- Arbitrates 64-bit SPI capture records from two requesters (MOSI-frame and MISO-frame assemblers) onto one shared write port of a 64x64 capture memory.
- Sequences each accepted record into a ring of slots 1..63, then mirrors the next-slot index into slot 0.
- Provides a small Avalon-MM control/status register file (enable, stop-on-full, fill count, drop count, clear) for the debug host.

Parameters:
- ADDR_W, 6, capture memory address width; depth = 2^ADDR_W, slot 0 reserved for pointer mirror.
- DATA_W, 64, record and Avalon data width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_MOSI_Valid  in  1  MOSI record offered; held until accepted
- io_MOSI_Record  in  DATA_W  MOSI record payload
- io_MOSI_Ready  out  1  MOSI record consumed this cycle
- io_MISO_Valid  in  1  MISO record offered; held until accepted
- io_MISO_Record  in  DATA_W  MISO record payload
- io_MISO_Ready  out  1  MISO record consumed this cycle
- io_Mem_WriteEnable  out  1  capture memory write strobe
- io_Mem_WriteAddress  out  ADDR_W  capture memory slot
- io_Mem_WriteData  out  DATA_W  capture memory data
- io_Avalon_address  in  2  register select
- io_Avalon_read  in  1  register read
- io_Avalon_readdata  out  DATA_W  register read data, combinational from address
- io_Avalon_write  in  1  register write
- io_Avalon_writedata  in  DATA_W  register write data
- io_Avalon_waitrequest  out  1  stall Avalon write

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE; wptr = 1; count = 0; drops = 0; CTRL.enable = 1; CTRL.stop_on_full = 0; rr_last = MISO, so MOSI wins the first tie.
  - All outputs 0.
- FSM states: IDLE, WRITE_REC, WRITE_PTR, CLEAR_PTR.
- IDLE:
  - Pending clear has priority: go to CLEAR_PTR; no ready asserted that cycle.
  - Otherwise, if any valid is high, grant one requester. Only one is valid: grant it. Both valid: grant the one that is not rr_last.
  - The granted Ready is pulsed for exactly one cycle (combinational from IDLE && grant). Record latched; rr_last updated.
  - enable=0: grant still happens and the record is discarded, not counted; stay in IDLE.
  - enable=1, stop_on_full=1, count==63: record discarded; drops incremented (saturating at 2^32-1); stay in IDLE.
  - Otherwise go to WRITE_REC.
- WRITE_REC:
  - WE=1, address=wptr, data=latched record.
  - wptr_next = (wptr==63) ? 1 : wptr+1, so slot 0 is never written with a record.
  - count increments, saturating at 63.
  - Go to WRITE_PTR.
- WRITE_PTR: WE=1, address=0, data=zero-extended wptr (already advanced); go to IDLE.
- CLEAR_PTR:
  - wptr=1, count=0, drops=0.
  - WE=1, address=0, data=1; go to IDLE.
- Latency and throughput:
  - Accept in cycle N; record written in N+1; pointer written in N+2; next grant possible in N+3.
  - Maximum throughput is 1 record per 3 cycles.
- Wrap: with stop_on_full=0, the oldest slots are overwritten; count stays 63.
- Avalon registers (read has zero latency, waitrequest never asserted for reads):
  - 0 CTRL: bit0 enable, bit1 stop_on_full; read/write.
  - 1 STATUS: [5:0] wptr, [13:8] count, bit16 full (count==63), bit17 busy (FSM!=IDLE); read-only.
  - 2 DROPS: [31:0]; read-only.
  - 3 CLEAR: any write requests a clear; reads return 0.
- Clear handshake: a write to 3 while FSM!=IDLE holds waitrequest=1 until FSM returns to IDLE. It is then accepted and CLEAR_PTR follows. An in-flight record always completes both writes before the clear.
- CTRL writes take effect in the following cycle and never stall.
- Reset mid-operation: FSM returns to IDLE. A partially written record is abandoned; the host must clear.
- Requester contract: Valid and Record stable from assertion until the Ready cycle.

Decomposition:
- Shared package spi_capture_pkg:
  - FSM state enum.
  - Register address constants (REG_CTRL=0, REG_STATUS=1, REG_DROPS=2, REG_CLEAR=3).
  - CTRL bit indices; PTR_SLOT=0, FIRST_SLOT=1.
- One sub-module: spi_capture_rr_arbiter (2-way round-robin grant with rr_last state).

Test Plan:
- After reset, MOSI valid with 0xAA..AA -> Ready at cycle 1; writes (1, 0xAA..AA) at cycle 2 and (0, 2) at cycle 3; STATUS wptr=2, count=1.
- MOSI and MISO both valid continuously -> grants alternate MOSI, MISO, MOSI; records land in slots 1, 2, 3; a Ready pulse every 3 cycles.
- 64 records with stop_on_full=0 -> record 64 lands in slot 1; slot 0 holds 2; count=63, full=1.
- stop_on_full=1, 65 records -> records 64 and 65 get Ready but no memory write; DROPS=2; wptr=1.
- CLEAR written during WRITE_REC -> waitrequest high 2 cycles; record and pointer writes complete; then (0, 1) written; count=0, DROPS=0.
- enable=0, MISO valid -> Ready pulse, no WE, count unchanged.
